// File: rtl/instr_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_pkg
// Description : Shared fault encoding, default NOP word and fetch-stage record
//               for the pipelined instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_mem_pkg;

    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;
    localparam int FAULT_W        = 2;

    localparam int          DEFAULT_ADDR_WIDTH = 32;
    localparam int          DEFAULT_DATA_WIDTH = 32;
    localparam logic [31:0] DEFAULT_NOP_WORD   = 32'h0000_0000;

    typedef logic [FAULT_W-1:0] fault_t;

    // Stage record at the default widths; wider or narrower builds use an
    // identically laid out struct declared in the top.
    typedef struct packed {
        logic                          valid;
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
        fault_t                        fault;
    } fetch_stage_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_stage
// Description : One pipeline register of the fetch pipeline with load-enable
//               and synchronous clear back to the idle record.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_stage
    import instr_mem_pkg::*;
#(
    parameter type T       = fetch_stage_t,
    parameter T    RST_VAL = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  T     d,
    output T     q
);

    T stage_q;
    T stage_d;

    // Clear wins over enable so a flush also breaks a stall.
    always_comb begin
        stage_d = stage_q;
        if (clr) begin
            stage_d = RST_VAL;
        end else if (en) begin
            stage_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= RST_VAL;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_mem.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_mem
// Description : Pipelined instruction memory with valid/ready fetch port,
//               fault flagging, flush and run-time load port.
//               Optional macro INSTR_FETCH_MEM_PERF_EN adds fetch/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_mem
    import instr_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 64,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = DATA_WIDTH'(instr_mem_pkg::DEFAULT_NOP_WORD)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_instr,
    output logic [ADDR_WIDTH-1:0]    rsp_addr,
    output logic [1:0]               rsp_fault,
    input  logic                     flush,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_index,
    input  logic [DATA_WIDTH-1:0]    load_data
`ifdef INSTR_FETCH_MEM_PERF_EN
    ,
    output logic [31:0]              perf_fetches,
    output logic [31:0]              perf_stalls
`endif
);

    localparam int                    c_IDX_W   = $clog2(DEPTH);
    localparam int                    c_WIDX_W  = ADDR_WIDTH - 2;
    localparam logic [c_WIDX_W-1:0]   c_DEPTH_W = c_WIDX_W'(DEPTH);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        fault_t                fault;
    } stage_t;

    localparam stage_t c_STAGE_RST = '{valid: 1'b0, addr: '0, data: NOP_WORD, fault: '0};

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("instr_fetch_mem: READ_LATENCY must be within 1..4");
    end

    logic                  w_advance;
    logic                  w_accept;
    logic [c_WIDX_W-1:0]   w_word_idx;
    fault_t                w_fault;
    logic [DATA_WIDTH-1:0] w_rd_data;
    stage_t                w_stage_in;
    stage_t                w_stage_q [READ_LATENCY];

    // Program store: not reset, starts out as all NOPs.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: NOP_WORD};

    always_ff @(posedge clk) begin
        if (load_en && (int'(load_index) < DEPTH)) begin
            mem_q[load_index] <= load_data;
        end
    end

    // Range is judged on the full word index so high addresses never alias.
    always_comb begin
        w_word_idx                 = req_addr[ADDR_WIDTH-1:2];
        w_fault                    = '0;
        w_fault[FAULT_MISALIGN]    = |req_addr[1:0];
        w_fault[FAULT_RANGE]       = (w_word_idx >= c_DEPTH_W);
        w_rd_data                  = NOP_WORD;
        if (w_fault == '0) begin
            w_rd_data = mem_q[w_word_idx[c_IDX_W-1:0]];
        end
    end

    always_comb begin
        w_advance        = !rsp_valid || rsp_ready;
        req_ready        = w_advance && !flush;
        w_accept         = req_valid && req_ready;
        w_stage_in.valid = w_accept;
        w_stage_in.addr  = req_addr;
        w_stage_in.data  = w_rd_data;
        w_stage_in.fault = w_fault;
    end

    for (genvar i = 0; i < READ_LATENCY; i++) begin : g_stage
        stage_t w_d;
        if (i == 0) begin : g_first
            assign w_d = w_stage_in;
        end else begin : g_next
            assign w_d = w_stage_q[i-1];
        end

        instr_fetch_stage #(
            .T       (stage_t),
            .RST_VAL (c_STAGE_RST)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (w_advance),
            .clr   (flush),
            .d     (w_d),
            .q     (w_stage_q[i])
        );
    end

    assign rsp_valid = w_stage_q[READ_LATENCY-1].valid;
    assign rsp_instr = w_stage_q[READ_LATENCY-1].data;
    assign rsp_addr  = w_stage_q[READ_LATENCY-1].addr;
    assign rsp_fault = w_stage_q[READ_LATENCY-1].fault;

`ifdef INSTR_FETCH_MEM_PERF_EN
    logic [31:0] perf_fetches_q;
    logic [31:0] perf_fetches_d;
    logic [31:0] perf_stalls_q;
    logic [31:0] perf_stalls_d;

    // Saturating counters: they stick at all-ones rather than wrap.
    always_comb begin
        perf_fetches_d = perf_fetches_q;
        perf_stalls_d  = perf_stalls_q;
        if (w_accept && (perf_fetches_q != '1)) begin
            perf_fetches_d = perf_fetches_q + 32'd1;
        end
        if (req_valid && !req_ready && (perf_stalls_q != '1)) begin
            perf_stalls_d = perf_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetches_q <= '0;
            perf_stalls_q  <= '0;
        end else begin
            perf_fetches_q <= perf_fetches_d;
            perf_stalls_q  <= perf_stalls_d;
        end
    end

    assign perf_fetches = perf_fetches_q;
    assign perf_stalls  = perf_stalls_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_mem
// Description : Scoreboard bench for instr_fetch_mem (READ_LATENCY=2, DEPTH=64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_mem;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 64;
    localparam int          LAT   = 2;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_instr;
    logic [AW-1:0] rsp_addr;
    logic [1:0]    rsp_fault;
    logic          flush = 1'b0;
    logic          load_en = 1'b0;
    logic [5:0]    load_index = '0;
    logic [DW-1:0] load_data = '0;
`ifdef INSTR_FETCH_MEM_PERF_EN
    logic [31:0]   perf_fetches;
    logic [31:0]   perf_stalls;
`endif

    instr_fetch_mem #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .READ_LATENCY (LAT),
        .NOP_WORD     (NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_instr  (rsp_instr),
        .rsp_addr   (rsp_addr),
        .rsp_fault  (rsp_fault),
        .flush      (flush),
        .load_en    (load_en),
        .load_index (load_index),
        .load_data  (load_data)
`ifdef INSTR_FETCH_MEM_PERF_EN
        ,
        .perf_fetches (perf_fetches),
        .perf_stalls  (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [1:0]  fault;
        int          acc_cyc;
        bit          lat_exact;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [DEPTH];
    int          n_chk = 0;
    int          n_err = 0;
    int          m_fetches = 0;
    int          m_stalls = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: fault rules and read-before-write memory from the spec.
    function automatic exp_t model(input logic [31:0] a);
        exp_t e;
        e.addr      = a;
        e.fault[0]  = (a[1:0] != 2'b00);
        e.fault[1]  = ((a >> 2) >= DEPTH);
        e.instr     = (e.fault != 2'b00) ? NOP : model_mem[int'(a >> 2)];
        e.acc_cyc   = 0;
        e.lat_exact = 1'b0;
        return e;
    endfunction

    task automatic cycle(input bit v, input logic [31:0] a, input bit rr, input bit fl,
                         input bit le, input logic [5:0] li, input logic [31:0] ld, input bit lat);
        exp_t e;
        @(negedge clk);
        req_valid  = v;
        req_addr   = a;
        rsp_ready  = rr;
        flush      = fl;
        load_en    = le;
        load_index = li;
        load_data  = ld;
        #1;
        if (fl) sb_q.delete();
        if (v && req_ready) begin
            e           = model(a);
            e.acc_cyc   = cyc;
            e.lat_exact = lat;
            sb_q.push_back(e);
            m_fetches++;
        end
        if (v && !req_ready) m_stalls++;
        if (le) model_mem[li] = ld;
    endtask

    task automatic idle(input bit rr);
        cycle(1'b0, 32'h0, rr, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] a, input bit rr, input bit lat);
        cycle(1'b1, a, rr, 1'b0, 1'b0, 6'd0, 32'h0, lat);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            idle(1'b1);
            n++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard on each handshake and checks hold stability.
    bit          hold_prev = 1'b0;
    logic [31:0] prev_addr;
    logic [31:0] prev_instr;
    logic [1:0]  prev_fault;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_valid", 32'(rsp_valid), 32'd1);
                    check("hold_addr", rsp_addr, prev_addr);
                    check("hold_instr", rsp_instr, prev_instr);
                    check("hold_fault", 32'(rsp_fault), 32'(prev_fault));
                end
                if (rsp_valid && rsp_ready && !flush) begin
                    if (sb_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_rsp: got addr %h expected no response", rsp_addr);
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_addr", rsp_addr, e.addr);
                        check("rsp_instr", rsp_instr, e.instr);
                        check("rsp_fault", 32'(rsp_fault), 32'(e.fault));
                        if (e.lat_exact) check("latency", 32'(cyc - e.acc_cyc), 32'(LAT));
                    end
                end
                hold_prev  = rsp_valid && !rsp_ready && !flush;
                prev_addr  = rsp_addr;
                prev_instr = rsp_instr;
                prev_fault = rsp_fault;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;

        #2;
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_instr", rsp_instr, NOP);
        check("reset_addr", rsp_addr, 32'h0);
        check("reset_fault", 32'(rsp_fault), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b1;
        #1 check("idle_req_ready", 32'(req_ready), 32'd1);

        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd0, 32'h20080020, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd1, 32'h20090037, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd2, 32'h01098024, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd3, 32'h01098025, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd5, 32'h12345678, 1'b0);

        // Back-to-back program fetch with exact latency checks
        for (int i = 0; i < 4; i++) fetch(32'(i * 4), 1'b1, 1'b1);
        drain();

        // Faults: misaligned, out of range, both
        fetch(32'h6, 1'b1, 1'b0);
        fetch(32'h100, 1'b1, 1'b0);
        fetch(32'h102, 1'b1, 1'b0);
        fetch(32'hFFFF_FFF0, 1'b1, 1'b0);
        drain();

        // Stall for three cycles with a response presented
        fetch(32'h10, 1'b0, 1'b0);
        fetch(32'h14, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            fetch(32'h18, 1'b0, 1'b0);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        fetch(32'h18, 1'b1, 1'b0);
        fetch(32'h1C, 1'b1, 1'b0);
        drain();

        // Flush with two fetches in flight
        fetch(32'h0, 1'b1, 1'b0);
        fetch(32'h4, 1'b1, 1'b0);
        cycle(1'b1, 32'h8, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0, 1'b0);
        check("flush_req_ready", 32'(req_ready), 32'd0);
        fetch(32'h8, 1'b1, 1'b0);
        check("flush_clears_valid", 32'(rsp_valid), 32'd0);
        drain();

        // Same-cycle load and fetch: old word, then new word
        cycle(1'b1, 32'h14, 1'b1, 1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0);
        fetch(32'h14, 1'b1, 1'b0);
        drain();

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = {24'h0, 2'($urandom_range(0, 3)) == 2'd0 ? 6'd5 : 6'($urandom_range(0, 63)), 2'b00};
            else if (r == 7) a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            else if (r == 8) a = {22'($urandom_range(1, 4096)), 8'h0, 2'b00};
            else             a = $urandom;
            cycle(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
                  6'($urandom_range(0, 63)), $urandom, 1'b0);
        end
        drain();

`ifdef INSTR_FETCH_MEM_PERF_EN
        check("perf_fetches", perf_fetches, 32'(m_fetches));
        check("perf_stalls", perf_stalls, 32'(m_stalls));
`endif

        // Asynchronous reset with a response presented
        fetch(32'h0, 1'b0, 1'b0);
        fetch(32'h4, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        #3;
        check("pre_reset_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(rsp_valid), 32'd0);
        sb_q.delete();
        m_fetches = 0;
        m_stalls  = 0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("post_reset_valid", 32'(rsp_valid), 32'd0);
        check("post_reset_instr", rsp_instr, NOP);
        check("post_reset_addr", rsp_addr, 32'h0);
        check("post_reset_fault", 32'(rsp_fault), 32'd0);
`ifdef INSTR_FETCH_MEM_PERF_EN
        check("post_reset_fetches", perf_fetches, 32'd0);
        check("post_reset_stalls", perf_stalls, 32'd0);
`endif
        fetch(32'hC, 1'b1, 1'b1);
        drain();
        idle(1'b1);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_mem.md
Name: instr_fetch_mem

Overview:
- Parametrised, pipelined instruction memory for the pipelined MIPS core; successor of the combinational single-cycle instruction memory.
- Accepts word-aligned byte-address fetch requests over a valid/ready handshake and returns the instruction after READ_LATENCY cycles.
- Flags misaligned and out-of-range fetches, supports a pipeline flush on branch/jump redirect, and has a load port for filling program memory at run time.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, instruction width.
- DEPTH, 64, number of instruction words; index = req_addr >> 2.
- READ_LATENCY, 1, pipeline stages from accept to rsp_valid; legal range 1..4, elaboration error otherwise.
- NOP_WORD, 32'h00000000, value returned for faults and after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_addr  in  ADDR_WIDTH  byte address of the fetch.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_instr  out  DATA_WIDTH  fetched instruction.
- rsp_addr  out  ADDR_WIDTH  address belonging to rsp_instr.
- rsp_fault  out  2  bit0 misaligned (req_addr[1:0]!=0), bit1 out of range (index>=DEPTH).
- flush  in  1  discard all in-flight and presented responses.
- load_en  in  1  write load_data to memory.
- load_index  in  $clog2(DEPTH)  word index for the load.
- load_data  in  DATA_WIDTH  word to write.

Behaviour:
- Reset (async assert, sync release): all stage valids 0, rsp_valid 0, rsp_instr NOP_WORD, rsp_addr 0, rsp_fault 0. Memory contents are not reset; at elaboration every entry is initialised to NOP_WORD.
- Pipeline: READ_LATENCY stages, each holding {valid, addr, data, fault}. Stage 1 reads memory at acceptance; later stages shift. The final stage drives the rsp_* outputs.
- Advance condition: advance = !rsp_valid | rsp_ready. All stages shift together only when advance is high (global stall, no bubbles collapse).
- req_ready = advance & !flush. A request accepted in cycle N appears with rsp_valid in cycle N+READ_LATENCY, provided there are no stalls.
- Back-to-back throughput is 1 fetch/cycle while rsp_ready stays high.
- While rsp_valid & !rsp_ready: rsp_* and all stages hold stable; req_ready is 0.
- Faults: any nonzero fault bit forces rsp_instr = NOP_WORD. No memory read side effect. Both bits may be set together.
- Index is computed from req_addr[ADDR_WIDTH-1:2] at full width before the range compare; there is no wrap-around and no truncation aliasing.
- Flush: all stage valids and rsp_valid clear on the next edge. Requests are not accepted in the flush cycle. Flush overrides stall.
- Load: load_en writes on the clock edge, independent of the handshake and of stall. A fetch of the same index in the same cycle returns the old word (read-before-write). Fetches accepted in later cycles see the new word.
- Reset mid-operation: all in-flight fetches are dropped immediately; no response is produced for them.

Optional Feature:
- INSTR_FETCH_MEM_PERF_EN defined:
  - Adds outputs perf_fetches (32-bit) and perf_stalls (32-bit).
  - perf_fetches increments per accepted request, faults included.
  - perf_stalls increments each cycle with req_valid & !req_ready.
  - Both saturate at all-ones and reset to 0.
- Not defined: the ports and counters are absent, and the behaviour is otherwise identical.

Decomposition:
- Shared package instr_mem_pkg:
  - fault bit positions FAULT_MISALIGN=0 and FAULT_RANGE=1.
  - default NOP_WORD.
  - fetch-stage struct {valid, addr, data, fault}.
- One natural sub-module, instr_fetch_stage: a single pipeline register with load-enable and clear, instantiated READ_LATENCY times by a generate loop.

Test Plan:
- Reset, then load indices 0..3 with 32'h20080020, 32'h20090037, 32'h01098024, 32'h01098025. Fetch addresses 0,4,8,12 back-to-back with READ_LATENCY=2 and rsp_ready=1 -> responses arrive in order from cycle 2 of issue, at one per cycle, with rsp_fault=0.
- Fetch 0x6 -> rsp_fault=2'b01, rsp_instr=NOP_WORD. Fetch 0x100 with DEPTH=64 -> rsp_fault=2'b10. Fetch 0x102 -> 2'b11.
- Hold rsp_ready=0 for 3 cycles with a response presented -> rsp_* stable and req_ready=0; release -> remaining fetches complete in order with none lost or duplicated.
- Assert flush with 2 fetches in flight -> rsp_valid=0 next cycle, and neither response ever appears. The request after flush returns the correct word.
- In the same cycle, load index 5 with 32'hDEADBEEF and fetch 0x14 -> old word returned; a fetch of 0x14 one cycle later -> 32'hDEADBEEF.
- Assert rst_n low mid-stream -> rsp_valid falls without waiting for a clock edge; after release the outputs are at reset values and counters (PERF_EN build) read 0.
